mux_rr_sel: RTL and testbench

- Parametrised N-way, W-bit multiplexer. It replaces the fixed 4-bit 2:1 combinational select in the datapath.
- Adds per-channel valid/ready handshakes, a registered output stage, and two arbitration modes: fixed select and round-robin.
- Sits between several operand producers (e.g. operand/difference units) and a single downstream consumer.
- Throughput is one word per cycle.

---
 rtl/mux_rr_sel.sv | 136 +++++++++++++
 tb/tb_mux_rr_sel.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_sel.sv
// rtl/mux_rr_sel.sv - N-way W-bit registered mux with fixed-select and round-robin grant
module mux_rr_sel #(
  parameter int W    = 4,
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*W-1:0]    in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_ch,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    data_q, data_d;
  logic [SELW-1:0] ch_q;
  logic [SELW-1:0] ptr_q;

  logic            fix_ok;
  logic            rr_found;
  logic [SELW-1:0] rr_idx;
  logic [SELW-1:0] rr_cand;
  logic            gnt_valid;
  logic [SELW-1:0] gnt_idx;
  logic            load_en;
  logic            xfer_in;

  // Fixed select: match sel against every real channel, so an out-of-range sel never grants
  always_comb begin
    fix_ok = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SELW'(i)) begin
        fix_ok = in_valid[i];
      end
    end
  end

  // Round-robin: first valid channel searching ptr+1, ptr+2, ... modulo N
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = '0;
    for (int k = 1; k <= N; k++) begin
      rr_cand = SELW'((int'(ptr_q) + k) % N);
      if (!rr_found && in_valid[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  // Grant selection, load enable and the single input transfer strobe
  always_comb begin
    gnt_valid = mode ? rr_found : fix_ok;
    gnt_idx   = mode ? rr_idx : sel;
    load_en   = (state_q == ST_EMPTY) | (out_ready & out_valid);
    xfer_in   = gnt_valid & load_en & ~rst;
  end

  // One-hot accept toward the granted producer; silent during reset or backpressure
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = xfer_in & (gnt_idx == SELW'(i));
    end
  end

  // Data word of the granted channel, passed bit-exact
  always_comb begin
    data_d = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SELW'(i)) begin
        data_d = in_data[i*W +: W];
      end
    end
  end

  // Output stage state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Output stage next state: refill on input transfer, drain when consumed with nothing to load
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (xfer_in) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          state_d = xfer_in ? ST_FULL : ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Output stage outputs
  always_comb begin
    out_valid = (state_q == ST_FULL);
    out_data  = data_q;
    out_ch    = ch_q;
  end

  // Output word, source channel and round-robin pointer capture on each input transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      ch_q   <= '0;
      ptr_q  <= SELW'(N - 1);
    end else if (xfer_in) begin
      data_q <= data_d;
      ch_q   <= gnt_idx;
      ptr_q  <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_mux_rr_sel.sv
// tb/tb_mux_rr_sel.sv - scoreboard bench for mux_rr_sel
module tb_mux_rr_sel;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  logic [11:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic        mode3;
  logic [1:0]  sel3;
  logic [3:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3;
  logic        out_ready3;

  int checks = 0;
  int errors = 0;
  logic [5:0] sb_q[$];

  mux_rr_sel #(.W(4), .N(4), .SELW(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  mux_rr_sel #(.W(4), .N(3), .SELW(2)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .mode(mode3), .sel(sel3), .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1 with inputs set; checks in_ready, records the expected word, advances one cycle
  task automatic step(input string name, input logic [3:0] exp_rdy,
                      input logic [3:0] d, input logic [1:0] ch);
    #3;
    chk(name, {28'd0, in_ready}, {28'd0, exp_rdy});
    if (exp_rdy != 4'd0) sb_q.push_back({d, ch});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
  endtask

  // Monitor: every output transfer must match the oldest expected word
  always @(negedge clk) begin
    logic [5:0] exp_w;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got data %0h ch %0d with no expected word", out_data, out_ch);
      end else begin
        exp_w = sb_q.pop_front();
        if ({out_data, out_ch} !== exp_w) begin
          errors++;
          $display("FAIL sb_word: got data %0h ch %0d expected data %0h ch %0d",
                   out_data, out_ch, exp_w[5:2], exp_w[1:0]);
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    in_data    = 16'h0000;
    in_valid   = 4'b1111;
    mode       = 1'b0;
    sel        = 2'd0;
    out_ready  = 1'b1;
    in_data3   = 12'h000;
    in_valid3  = 3'b000;
    mode3      = 1'b0;
    sel3       = 2'd0;
    out_ready3 = 1'b1;

    // reset state
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {28'd0, out_data}, 32'd0);
    chk("rst_out_ch", {30'd0, out_ch}, 32'd0);
    chk("rst_in_ready", {28'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 4'b0000;

    // N=3 instance: out-of-range sel never grants, in-range sel does
    in_valid3 = 3'b111;
    sel3      = 2'd3;
    in_data3  = 12'h654;
    #3;
    chk("n3_oor_ready", {29'd0, in_ready3}, 32'd0);
    @(posedge clk);
    #1;
    chk("n3_oor_valid", {31'd0, out_valid3}, 32'd0);
    sel3 = 2'd2;
    #3;
    chk("n3_sel2_ready", {29'd0, in_ready3}, 32'b100);
    @(posedge clk);
    #1;
    in_valid3 = 3'b000;
    chk("n3_sel2_valid", {31'd0, out_valid3}, 32'd1);
    chk("n3_sel2_data", {28'd0, out_data3}, 32'h6);
    chk("n3_sel2_ch", {30'd0, out_ch3}, 32'd2);

    // fixed select ch2
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data = 16'h0700;
    step("fix_sel2_ready", 4'b0100, 4'h7, 2'd2);
    in_valid = 4'b0000;
    chk("fix_out_valid", {31'd0, out_valid}, 32'd1);
    chk("fix_out_data", {28'd0, out_data}, 32'h7);
    chk("fix_out_ch", {30'd0, out_ch}, 32'd2);
    step("fix_idle_ready", 4'b0000, 4'h0, 2'd0);

    // sel points at a non-valid channel
    sel = 2'd1; in_valid = 4'b1101; in_data = 16'h4321;
    step("inv_sel_ready", 4'b0000, 4'h0, 2'd0);
    chk("inv_sel_valid", {31'd0, out_valid}, 32'd0);

    // round-robin fairness from reset
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; in_data = 16'h4321; out_ready = 1'b1;
    step("rr0_ready", 4'b0001, 4'h1, 2'd0);
    step("rr1_ready", 4'b0010, 4'h2, 2'd1);
    step("rr2_ready", 4'b0100, 4'h3, 2'd2);
    step("rr3_ready", 4'b1000, 4'h4, 2'd3);
    step("rr4_ready", 4'b0001, 4'h1, 2'd0);
    in_valid = 4'b0000;
    step("rr_drain_ready", 4'b0000, 4'h0, 2'd0);

    // backpressure hold, then reload in the same cycle out_ready rises
    mode = 1'b0; sel = 2'd1; in_valid = 4'b1111; in_data = 16'h4351;
    step("bp_load_ready", 4'b0010, 4'h5, 2'd1);
    mode = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step("bp_hold_ready", 4'b0000, 4'h0, 2'd0);
      chk("bp_hold_data", {28'd0, out_data}, 32'h5);
      chk("bp_hold_ch", {30'd0, out_ch}, 32'd1);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    step("bp_release_ready", 4'b0100, 4'h3, 2'd2);
    chk("bp_next_data", {28'd0, out_data}, 32'h3);
    in_valid = 4'b0000;
    step("bp_drain_ready", 4'b0000, 4'h0, 2'd0);

    // mode switch: fixed serves ch1, round-robin then wraps 2,3,0
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0011; in_data = 16'h4351;
    step("ms_fix_ready", 4'b0010, 4'h5, 2'd1);
    mode = 1'b1;
    step("ms_rr_wrap_ready", 4'b0001, 4'h1, 2'd0);
    step("ms_rr_next_ready", 4'b0010, 4'h5, 2'd1);
    in_valid = 4'b0000;
    step("ms_drain_ready", 4'b0000, 4'h0, 2'd0);

    // asynchronous reset while FULL holding A
    mode = 1'b0; sel = 2'd3; in_valid = 4'b1000; in_data = 16'hA000; out_ready = 1'b0;
    step("rst_load_ready", 4'b1000, 4'hA, 2'd3);
    in_valid = 4'b1111;
    #1;
    chk("rst_pre_data", {28'd0, out_data}, 32'hA);
    chk("rst_pre_ready", {28'd0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_async_data", {28'd0, out_data}, 32'd0);
    chk("rst_async_ch", {30'd0, out_ch}, 32'd0);
    chk("rst_async_ready", {28'd0, in_ready}, 32'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 4'b0000;
    out_ready = 1'b1;
    step("post_rst_ready", 4'b0000, 4'h0, 2'd0);
    step("post_rst_ready2", 4'b0000, 4'h0, 2'd0);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
